nip_multi_buffer_writer: RTL and testbench

- Parametrised successor of the single-port input buffer interface in the network input process.
- Accepts 134-bit packet words plus buffer IDs from NUM_CH frame parsers and queues each channel in its own FIFO.
- Arbitrates round-robin at packet granularity and writes the words into the shared packet buffer at {bufid, word_idx}.
- New over the single-port version: admission control with bufid release on drop, overlength truncation, and a missing-tail recovery path.

---
 rtl/nip_pkg.sv | 15 +
 rtl/nip_sync_fifo.sv | 50 +++++
 rtl/nip_multi_buffer_writer.sv | 234 +++++++++++++++++++++++
 tb/tb_nip_multi_buffer_writer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nip_pkg.sv
// Shared widths and FSM encodings for the network input multi-buffer writer.
package nip_pkg;
  localparam int PKT_W    = 134;
  localparam int HEAD_BIT = 133;
  localparam int TAIL_BIT = 132;
  localparam int BUFID_W  = 9;

  localparam logic [1:0] ARB_IDLE     = 2'd0;
  localparam logic [1:0] ARB_FETCH    = 2'd1;
  localparam logic [1:0] ARB_WAIT_ACK = 2'd2;

  localparam logic [1:0] IN_WAIT_HEAD = 2'd0;
  localparam logic [1:0] IN_ACCEPT    = 2'd1;
  localparam logic [1:0] IN_DROP      = 2'd2;
endpackage

// File: rtl/nip_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; DEPTH must be a power of 2, >= 2.
module nip_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   i_wr,
  input  logic [WIDTH-1:0]       iv_data,
  input  logic                   i_rd,
  output logic [WIDTH-1:0]       ov_q,
  output logic [$clog2(DEPTH):0] ov_usedw,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_usedw;
  logic             w_push, w_pop;

  assign o_full   = (r_usedw == CNT_FULL);
  assign o_empty  = (r_usedw == '0);
  assign w_push   = i_wr && !o_full;
  assign w_pop    = i_rd && !o_empty;
  assign ov_q     = r_mem[r_rd_ptr];
  assign ov_usedw = r_usedw;

  always_ff @(posedge clk_sys) begin
    if (w_push) r_mem[r_wr_ptr] <= iv_data;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usedw  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_usedw <= r_usedw + (AW+1)'(1);
        2'b01:   r_usedw <= r_usedw - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/nip_multi_buffer_writer.sv
// Per-channel admission/truncation front ends feeding FIFOs, drained by a packet-granular
// round-robin arbiter into the shared packet buffer at {bufid, word_idx}.
module nip_multi_buffer_writer
  import nip_pkg::*;
#(
  parameter  int NUM_CH        = 4,
  parameter  int DATA_DEPTH    = 256,
  parameter  int BUFID_DEPTH   = 4,
  parameter  int MAX_PKT_WORDS = 128,
  localparam int WIDX_W        = $clog2(MAX_PKT_WORDS)
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           i_pkt_wr,
  input  logic [NUM_CH*PKT_W-1:0]     iv_pkt,
  input  logic [NUM_CH*BUFID_W-1:0]   iv_pkt_bufid,
  output logic [PKT_W-1:0]            ov_pkt,
  output logic                        o_pkt_wr,
  output logic [BUFID_W+WIDX_W-1:0]   ov_pkt_bufadd,
  input  logic                        i_pkt_ack,
  output logic [NUM_CH-1:0]           o_bufid_release,
  output logic [NUM_CH*BUFID_W-1:0]   ov_release_bufid,
  output logic [NUM_CH-1:0]           o_discard_pulse,
  output logic [NUM_CH-1:0]           o_overlength_pulse,
  output logic [NUM_CH-1:0]           o_notail_pulse,
  output logic [1:0]                  ov_arb_state,
  output logic [2:0]                  ov_cur_ch
);
  localparam int DUW = $clog2(DATA_DEPTH) + 1;
  localparam logic [DUW-1:0]    ADMIT_MAX = DUW'(DATA_DEPTH - MAX_PKT_WORDS);
  localparam logic [WIDX_W-1:0] CNT_LAST  = WIDX_W'(MAX_PKT_WORDS - 1);

  logic [NUM_CH-1:0]  w_d_push, w_d_pop, w_d_empty, w_d_full;
  logic [NUM_CH-1:0]  w_b_push, w_b_pop, w_b_empty, w_b_full;
  logic [PKT_W-1:0]   w_d_din [NUM_CH];
  logic [PKT_W-1:0]   w_d_q   [NUM_CH];
  logic [BUFID_W-1:0] w_b_q   [NUM_CH];
  logic [DUW-1:0]     w_d_usedw [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PKT_W-1:0]   w_word, w_din;
    logic [BUFID_W-1:0] w_bufid, r_rel_bufid;
    logic               w_head, w_tail, w_admit, w_push, w_bpush, r_drop, r_ovl;
    logic [1:0]         r_in_st;
    logic [WIDX_W-1:0]  r_cnt;

    assign w_word  = iv_pkt[c*PKT_W +: PKT_W];
    assign w_bufid = iv_pkt_bufid[c*BUFID_W +: BUFID_W];
    assign w_head  = w_word[HEAD_BIT];
    assign w_tail  = w_word[TAIL_BIT];
    // Reserving a full MAX_PKT_WORDS per admitted packet means the data FIFO never overflows.
    assign w_admit = (w_d_usedw[c] <= ADMIT_MAX) && !w_b_full[c] && !w_d_full[c];

    always_comb begin
      w_push  = 1'b0;
      w_bpush = 1'b0;
      w_din   = w_word;
      if (i_pkt_wr[c]) begin
        if (w_head) begin
          w_push  = w_admit;
          w_bpush = w_admit;
        end else if (r_in_st == IN_ACCEPT) begin
          w_push = 1'b1;
          if (!w_tail && r_cnt == CNT_LAST) w_din[TAIL_BIT] = 1'b1;
        end
      end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        r_in_st     <= IN_WAIT_HEAD;
        r_cnt       <= '0;
        r_drop      <= 1'b0;
        r_ovl       <= 1'b0;
        r_rel_bufid <= '0;
      end else begin
        r_drop <= 1'b0;
        r_ovl  <= 1'b0;
        if (i_pkt_wr[c]) begin
          if (w_head) begin
            if (w_admit) begin
              r_in_st <= w_tail ? IN_WAIT_HEAD : IN_ACCEPT;
              r_cnt   <= WIDX_W'(1);
            end else begin
              r_in_st     <= IN_DROP;
              r_drop      <= 1'b1;
              r_rel_bufid <= w_bufid;
            end
          end else begin
            case (r_in_st)
              IN_ACCEPT: begin
                if (w_tail) r_in_st <= IN_WAIT_HEAD;
                else if (r_cnt == CNT_LAST) begin
                  r_in_st <= IN_DROP;
                  r_ovl   <= 1'b1;
                end else r_cnt <= r_cnt + WIDX_W'(1);
              end
              IN_DROP: if (w_tail) r_in_st <= IN_WAIT_HEAD;
              default: ;
            endcase
          end
        end
      end
    end

    assign w_d_push[c]                          = w_push;
    assign w_b_push[c]                          = w_bpush;
    assign w_d_din[c]                           = w_din;
    assign o_bufid_release[c]                   = r_drop;
    assign o_discard_pulse[c]                   = r_drop;
    assign o_overlength_pulse[c]                = r_ovl;
    assign ov_release_bufid[c*BUFID_W +: BUFID_W] = r_rel_bufid;

    nip_sync_fifo #(.WIDTH(PKT_W), .DEPTH(DATA_DEPTH)) u_data_fifo (
      .clk_sys (clk_sys), .reset (reset), .i_wr (w_d_push[c]), .iv_data (w_d_din[c]),
      .i_rd (w_d_pop[c]), .ov_q (w_d_q[c]), .ov_usedw (w_d_usedw[c]),
      .o_full (w_d_full[c]), .o_empty (w_d_empty[c])
    );

    nip_sync_fifo #(.WIDTH(BUFID_W), .DEPTH(BUFID_DEPTH)) u_bufid_fifo (
      .clk_sys (clk_sys), .reset (reset), .i_wr (w_b_push[c]), .iv_data (w_bufid),
      .i_rd (w_b_pop[c]), .ov_q (w_b_q[c]), .ov_usedw (),
      .o_full (w_b_full[c]), .o_empty (w_b_empty[c])
    );
  end

  logic [1:0]         r_arb_st;
  logic [2:0]         r_cur, r_rr;
  logic [BUFID_W-1:0] r_bufid;
  logic [WIDX_W-1:0]  r_widx;
  logic [PKT_W-1:0]   r_pkt;
  logic               r_wr;
  logic [NUM_CH-1:0]  r_notail;

  logic               w_hit, w_front_empty, w_fetch_pop, w_stream_pop, w_ack;
  logic [2:0]         w_sel;
  logic [PKT_W-1:0]   w_front;
  logic [BUFID_W-1:0] w_sel_bufid;

  always_comb begin
    w_hit         = 1'b0;
    w_sel         = '0;
    w_sel_bufid   = '0;
    w_front       = '0;
    w_front_empty = 1'b1;
    // Descending offset so the channel nearest rr+1 is the last (winning) assignment.
    for (int j = NUM_CH; j >= 1; j--) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (((int'(r_rr) + j) % NUM_CH) == c && !w_b_empty[c]) begin
          w_hit = 1'b1;
          w_sel = 3'(c);
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_sel == 3'(c)) w_sel_bufid = w_b_q[c];
      if (r_cur == 3'(c)) begin
        w_front       = w_d_q[c];
        w_front_empty = w_d_empty[c];
      end
    end
  end

  assign w_ack        = r_wr && i_pkt_ack;
  assign w_fetch_pop  = (r_arb_st == ARB_FETCH) && !w_front_empty &&
                        !(w_front[HEAD_BIT] && r_widx != '0);
  assign w_stream_pop = (r_arb_st == ARB_WAIT_ACK) && w_ack && !r_pkt[TAIL_BIT] &&
                        !w_front_empty && !w_front[HEAD_BIT];

  always_comb begin
    w_d_pop = '0;
    w_b_pop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_d_pop[c] = (w_fetch_pop || w_stream_pop) && (r_cur == 3'(c));
      w_b_pop[c] = (r_arb_st == ARB_IDLE) && w_hit && (w_sel == 3'(c));
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_arb_st <= ARB_IDLE;
      r_cur    <= '0;
      r_rr     <= 3'(NUM_CH - 1);
      r_bufid  <= '0;
      r_widx   <= '0;
      r_pkt    <= '0;
      r_wr     <= 1'b0;
      r_notail <= '0;
    end else begin
      r_notail <= '0;
      case (r_arb_st)
        ARB_IDLE: if (w_hit) begin
          r_cur    <= w_sel;
          r_bufid  <= w_sel_bufid;
          r_widx   <= '0;
          r_arb_st <= ARB_FETCH;
        end
        ARB_FETCH: if (!w_front_empty) begin
          if (w_front[HEAD_BIT] && r_widx != '0) begin
            for (int c = 0; c < NUM_CH; c++) r_notail[c] <= (r_cur == 3'(c));
            r_rr     <= r_cur;
            r_arb_st <= ARB_IDLE;
          end else begin
            r_pkt    <= w_front;
            r_wr     <= 1'b1;
            r_arb_st <= ARB_WAIT_ACK;
          end
        end
        ARB_WAIT_ACK: if (w_ack) begin
          if (r_pkt[TAIL_BIT]) begin
            r_wr     <= 1'b0;
            r_rr     <= r_cur;
            r_arb_st <= ARB_IDLE;
          end else if (w_stream_pop) begin
            r_pkt  <= w_front;
            r_widx <= r_widx + WIDX_W'(1);
          end else begin
            r_wr     <= 1'b0;
            r_widx   <= r_widx + WIDX_W'(1);
            r_arb_st <= ARB_FETCH;
          end
        end
        default: r_arb_st <= ARB_IDLE;
      endcase
    end
  end

  assign ov_pkt         = r_pkt;
  assign o_pkt_wr       = r_wr;
  assign ov_pkt_bufadd  = {r_bufid, r_widx};
  assign o_notail_pulse = r_notail;
  assign ov_arb_state   = r_arb_st;
  assign ov_cur_ch      = r_cur;
endmodule

// File: tb/tb_nip_multi_buffer_writer.sv
// Directed bench: expected buffer writes are queued as stimulus is driven and
// checked in order on every o_pkt_wr/i_pkt_ack handshake.
module tb_nip_multi_buffer_writer;
  localparam int NUM_CH = 4;
  localparam int PKT_W  = 134;
  localparam int BW     = 9;
  localparam int AW     = 16;

  logic                   clk_sys = 1'b0;
  logic                   reset;
  logic [NUM_CH-1:0]      i_pkt_wr;
  logic [NUM_CH*PKT_W-1:0] iv_pkt;
  logic [NUM_CH*BW-1:0]   iv_pkt_bufid;
  logic [PKT_W-1:0]       ov_pkt;
  logic                   o_pkt_wr;
  logic [AW-1:0]          ov_pkt_bufadd;
  logic                   i_pkt_ack;
  logic [NUM_CH-1:0]      o_bufid_release, o_discard_pulse, o_overlength_pulse, o_notail_pulse;
  logic [NUM_CH*BW-1:0]   ov_release_bufid;
  logic [1:0]             ov_arb_state;
  logic [2:0]             ov_cur_ch;

  int tests = 0, errors = 0;
  int n_writes = 0, n_notail = 0, n_ovl = 0;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [PKT_W-1:0] pkt;
  } exp_t;
  exp_t sb[$];
  exp_t e_mon;

  always #5 clk_sys = ~clk_sys;

  nip_multi_buffer_writer #(
    .NUM_CH(4), .DATA_DEPTH(256), .BUFID_DEPTH(4), .MAX_PKT_WORDS(128)
  ) dut (
    .clk_sys (clk_sys), .reset (reset), .i_pkt_wr (i_pkt_wr), .iv_pkt (iv_pkt),
    .iv_pkt_bufid (iv_pkt_bufid), .ov_pkt (ov_pkt), .o_pkt_wr (o_pkt_wr),
    .ov_pkt_bufadd (ov_pkt_bufadd), .i_pkt_ack (i_pkt_ack),
    .o_bufid_release (o_bufid_release), .ov_release_bufid (ov_release_bufid),
    .o_discard_pulse (o_discard_pulse), .o_overlength_pulse (o_overlength_pulse),
    .o_notail_pulse (o_notail_pulse), .ov_arb_state (ov_arb_state), .ov_cur_ch (ov_cur_ch)
  );

  function automatic logic [PKT_W-1:0] mkw(logic h, logic t, int ch, int bufid, int k);
    logic [127:0] d;
    d = {32'hA5A5_0000 + 32'(ch), 32'(bufid), 32'(k), 32'h5A5A_FFFF};
    return {h, t, (t ? 4'hF : 4'h0), d};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(logic [BW-1:0] bufid, int k, logic [PKT_W-1:0] w);
    exp_t e;
    e.addr = {bufid, 7'(k)};
    e.pkt  = w;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(int ch, logic [PKT_W-1:0] w, logic [BW-1:0] b);
    i_pkt_wr[ch] = 1'b1;
    iv_pkt[ch*PKT_W +: PKT_W] = w;
    iv_pkt_bufid[ch*BW +: BW] = b;
    tick();
    i_pkt_wr = '0;
  endtask

  task automatic send_pkt(int ch, logic [BW-1:0] b, int n);
    for (int k = 0; k < n; k++) sb_push(b, k, mkw(k == 0, k == n-1, ch, int'(b), k));
    for (int k = 0; k < n; k++) send(ch, mkw(k == 0, k == n-1, ch, int'(b), k), b);
  endtask

  task automatic drain(string tag, int budget);
    int i;
    i = 0;
    while (sb.size() != 0 && i < budget) begin
      tick();
      i++;
    end
    repeat (3) tick();
    check({tag, "_drained"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  always @(negedge clk_sys) begin
    if (o_notail_pulse[0]) n_notail++;
    if (o_overlength_pulse[0]) n_ovl++;
    if (o_pkt_wr && i_pkt_ack) begin
      n_writes++;
      tests++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr %0h, expected no write", ov_pkt_bufadd);
      end
      if (sb.size() > 0) begin
        e_mon = sb.pop_front();
        tests++;
        assert (ov_pkt_bufadd === e_mon.addr) else begin
          errors++;
          $error("FAIL wr_addr: observed %0h expected %0h", ov_pkt_bufadd, e_mon.addr);
        end
        tests++;
        assert (ov_pkt === e_mon.pkt) else begin
          errors++;
          $error("FAIL wr_data @%0h: observed %0h expected %0h", e_mon.addr, ov_pkt, e_mon.pkt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap;
    logic [PKT_W-1:0] w;
    reset = 1'b1; i_pkt_wr = '0; iv_pkt = '0; iv_pkt_bufid = '0; i_pkt_ack = 1'b1;
    repeat (3) tick();
    check("rst_pkt_wr", 64'(o_pkt_wr), 64'd0);
    check("rst_arb_state", 64'(ov_arb_state), 64'd0);
    check("rst_bufadd", 64'(ov_pkt_bufadd), 64'd0);
    check("rst_pulses", 64'({o_bufid_release, o_discard_pulse, o_overlength_pulse, o_notail_pulse}), 64'd0);
    check("rst_cur_ch", 64'(ov_cur_ch), 64'd0);
    reset = 1'b0;
    repeat (2) tick();

    // single 3-word packet on ch0
    for (int k = 0; k < 3; k++) begin
      w = mkw(k == 0, k == 2, 0, 5, k);
      sb.push_back('{16'h0280 + 16'(k), w});
    end
    for (int k = 0; k < 3; k++) send(0, mkw(k == 0, k == 2, 0, 5, k), 9'h005);
    drain("t1", 50);
    check("t1_arb_idle", 64'(ov_arb_state), 64'd0);

    // ch1/ch2 tie after ch0 served: ch1 wins
    for (int k = 0; k < 2; k++) sb_push(9'h011, k, mkw(k == 0, k == 1, 1, 'h11, k));
    for (int k = 0; k < 2; k++) sb_push(9'h022, k, mkw(k == 0, k == 1, 2, 'h22, k));
    for (int k = 0; k < 2; k++) begin
      i_pkt_wr[2] = 1'b1;
      iv_pkt[2*PKT_W +: PKT_W] = mkw(k == 0, k == 1, 2, 'h22, k);
      iv_pkt_bufid[2*BW +: BW] = 9'h022;
      send(1, mkw(k == 0, k == 1, 1, 'h11, k), 9'h011);
    end
    drain("t2a", 50);
    // ch1 served alone, then a tie: ch2 wins
    send_pkt(1, 9'h013, 2);
    drain("t2b", 50);
    for (int k = 0; k < 2; k++) sb_push(9'h024, k, mkw(k == 0, k == 1, 2, 'h24, k));
    for (int k = 0; k < 2; k++) sb_push(9'h014, k, mkw(k == 0, k == 1, 1, 'h14, k));
    for (int k = 0; k < 2; k++) begin
      i_pkt_wr[2] = 1'b1;
      iv_pkt[2*PKT_W +: PKT_W] = mkw(k == 0, k == 1, 2, 'h24, k);
      iv_pkt_bufid[2*BW +: BW] = 9'h024;
      send(1, mkw(k == 0, k == 1, 1, 'h14, k), 9'h014);
    end
    drain("t2c", 50);

    // fill ch3 to ~199 words with the arbiter stalled, then a head must be dropped
    i_pkt_ack = 1'b0;
    send_pkt(3, 9'h060, 100);
    send_pkt(3, 9'h061, 100);
    check("t3_stall_wr", 64'(o_pkt_wr), 64'd1);
    check("t3_stall_state", 64'(ov_arb_state), 64'd2);
    check("t3_stall_cur", 64'(ov_cur_ch), 64'd3);
    send(3, mkw(1, 0, 3, 'h1AB, 0), 9'h1AB);
    check("t3_release", 64'(o_bufid_release), 64'h8);
    check("t3_rel_bufid", 64'(ov_release_bufid[27 +: 9]), 64'h1AB);
    check("t3_discard", 64'(o_discard_pulse), 64'h8);
    send(3, mkw(0, 0, 3, 'h1AB, 1), 9'h1AB);
    check("t3_release_end", 64'(o_bufid_release), 64'd0);
    send(3, mkw(0, 1, 3, 'h1AB, 2), 9'h1AB);
    i_pkt_ack = 1'b1;
    drain("t3", 500);

    // 130-word packet on ch0: truncated at word 127 with forced tail
    for (int k = 0; k < 128; k++) begin
      w = mkw(k == 0, 1'b0, 0, 'h33, k);
      if (k == 127) w[132] = 1'b1;
      sb_push(9'h033, k, w);
    end
    for (int k = 0; k < 130; k++) begin
      send(0, mkw(k == 0, k == 129, 0, 'h33, k), 9'h033);
      if (k == 127) check("t4_ovl_pulse", 64'(o_overlength_pulse), 64'h1);
    end
    drain("t4", 400);
    check("t4_ovl_count", 64'(n_ovl), 64'd1);

    // missing tail: head, body, then new head
    sb_push(9'h040, 0, mkw(1, 0, 0, 'h40, 0));
    sb_push(9'h040, 1, mkw(0, 0, 0, 'h40, 1));
    for (int k = 0; k < 3; k++) sb_push(9'h041, k, mkw(k == 0, k == 2, 0, 'h41, k));
    send(0, mkw(1, 0, 0, 'h40, 0), 9'h040);
    send(0, mkw(0, 0, 0, 'h40, 1), 9'h040);
    for (int k = 0; k < 3; k++) send(0, mkw(k == 0, k == 2, 0, 'h41, k), 9'h041);
    drain("t5", 60);
    check("t5_notail_count", 64'(n_notail), 64'd1);

    // asynchronous reset while a write waits for ack
    i_pkt_ack = 1'b0;
    for (int k = 0; k < 3; k++) send(0, mkw(k == 0, k == 2, 0, 'h50, k), 9'h050);
    for (int i = 0; i < 20 && !o_pkt_wr; i++) tick();
    check("t6_wr_pending", 64'(o_pkt_wr), 64'd1);
    check("t6_wait_ack", 64'(ov_arb_state), 64'd2);
    #2 reset = 1'b1;
    #1;
    check("t6_async_wr", 64'(o_pkt_wr), 64'd0);
    check("t6_async_state", 64'(ov_arb_state), 64'd0);
    i_pkt_ack = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    snap = n_writes;
    send(0, mkw(0, 0, 0, 'h50, 5), 9'h050);
    send(0, mkw(0, 1, 0, 'h50, 6), 9'h050);
    repeat (10) tick();
    check("t6_no_write", 64'(n_writes - snap), 64'd0);
    check("t6_no_release", 64'(o_bufid_release), 64'd0);
    check("t6_idle", 64'(ov_arb_state), 64'd0);
    send_pkt(0, 9'h052, 2);
    drain("t6", 50);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
